kmap_sweeper: RTL and testbench

//   Stimulus/capture stage that sits directly upstream of a 4-input K-map logic block.
//   - Drives dut_in = {a,b,c,d} through all 2^N_IN combinations in ascending order.
//   - After a settle delay, samples the block's single output into a truth-table register.
//   - Compares each sample against an expected minterm mask; reports pass/fail,

---
 rtl/kmap_sweeper.sv | 125 ++++++++++++
 tb/tb_kmap_sweeper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_sweeper.sv
// Stimulus/capture stage for a 4-input K-map block: sweeps every input vector in
// ascending order, captures the block's output into a truth table and scores it.
module kmap_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic [N_IN:0]        err_count,
    output logic                 err_valid,
    output logic [N_IN-1:0]      first_err,
    output logic                 pass
);

    localparam int unsigned N_VEC = 2**N_IN;
    localparam int unsigned LAST  = N_VEC - 1;
    localparam int unsigned CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N_IN-1:0]     idx;
    logic [CW-1:0]       settle_cnt;
    logic [N_VEC-1:0]    expected_q;
    logic                last_c;
    logic                mismatch_c;

    assign last_c     = (idx == N_IN'(LAST));
    assign mismatch_c = (dut_out != expected_q[idx]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (settle_cnt == '0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_c ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            settle_cnt  <= '0;
            expected_q  <= '0;
            dut_in      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            err_count   <= '0;
            err_valid   <= 1'b0;
            first_err   <= '0;
            pass        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        expected_q  <= expected;
                        idx         <= '0;
                        settle_cnt  <= CW'(SETTLE - 1);
                        dut_in      <= '0;
                        busy        <= 1'b1;
                        truth_table <= '0;
                        err_count   <= '0;
                        err_valid   <= 1'b0;
                        first_err   <= '0;
                        pass        <= 1'b1;
                    end
                end
                WAIT: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
                end
                SAMPLE: begin
                    truth_table[idx] <= dut_out;
                    if (mismatch_c) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        err_valid <= 1'b1;
                        pass      <= 1'b0;
                        if (!err_valid) first_err <= idx;
                    end
                    if (last_c) begin
                        done <= 1'b1;
                    end else begin
                        idx        <= idx + N_IN'(1);
                        dut_in     <= idx + N_IN'(1);
                        settle_cnt <= CW'(SETTLE - 1);
                    end
                end
                DONE: begin
                    // dut_in deliberately keeps the final vector until the next start
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_sweeper.sv
// Bench for kmap_sweeper: two instances (SETTLE=1 and SETTLE=3) checked every cycle
// against a sweep-level model, plus literal expectations for the canonical scenarios.
module tb_kmap_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic [15:0] lut;
    logic [1:0]  glitch;

    logic [3:0]  dut_in      [2];
    logic        dut_out     [2];
    logic        busy        [2];
    logic        done        [2];
    logic [15:0] truth_table [2];
    logic [4:0]  err_count   [2];
    logic        err_valid   [2];
    logic [3:0]  first_err   [2];
    logic        pass        [2];

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    // model state per instance
    int          m_act   [2] = '{0, 0};
    int          m_k     [2] = '{0, 0};
    logic [15:0] m_exp   [2];
    logic [15:0] m_lut   [2];
    logic [15:0] m_tt    [2] = '{16'h0, 16'h0};
    int          m_err   [2] = '{0, 0};
    int          m_first [2] = '{0, 0};
    logic [3:0]  m_di    [2] = '{4'h0, 4'h0};

    always #5 clk = ~clk;

    assign dut_out[0] = lut[dut_in[0]] ^ glitch[0];
    assign dut_out[1] = lut[dut_in[1]] ^ glitch[1];

    kmap_sweeper #(.N_IN(4), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
        .truth_table(truth_table[0]), .err_count(err_count[0]), .err_valid(err_valid[0]),
        .first_err(first_err[0]), .pass(pass[0])
    );

    kmap_sweeper #(.N_IN(4), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
        .truth_table(truth_table[1]), .err_count(err_count[1]), .err_valid(err_valid[1]),
        .first_err(first_err[1]), .pass(pass[1])
    );

    function automatic int per_vec(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int done_cycle(input int i);
        return m_k[i] + 1 + 16 * per_vec(i);
    endfunction

    // Expected outputs in cycle c (the cycle that ends at edge c)
    task automatic model_at(input int i, input int c, output logic [3:0] e_di,
                            output logic e_busy, output logic e_done,
                            output logic [15:0] e_tt, output int e_err, output int e_first);
        int o, n, s;
        logic [15:0] mask, diff;
        if (m_act[i] != 0) begin
            s      = per_vec(i);
            o      = c - m_k[i];
            n      = (o - 1) / s;
            if (n > 16) n = 16;
            e_di   = (n > 15) ? 4'd15 : 4'(n);
            e_busy = 1'b1;
            e_done = (c == done_cycle(i));
            mask   = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
            e_tt   = m_lut[i] & mask;
            diff   = (m_lut[i] ^ m_exp[i]) & mask;
            e_err  = $countones(diff);
            e_first = 0;
            for (int b = 15; b >= 0; b--) if (diff[b]) e_first = b;
        end else begin
            e_di    = m_di[i];
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_tt    = m_tt[i];
            e_err   = m_err[i];
            e_first = m_first[i];
        end
    endtask

    task automatic chk(input string nm, input int i, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s u%0d at cycle %0d: got %0h, want %0h", nm, i, ecnt + 1, act, req);
        end
    endtask

    // Model update on every active edge
    always @(posedge clk) begin
        logic [3:0]  d;
        logic        b, dn;
        logic [15:0] t;
        int          er, fe;
        ecnt = ecnt + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0; m_tt[i] = '0; m_err[i] = 0; m_first[i] = 0; m_di[i] = '0;
            end else if (m_act[i] != 0) begin
                if (ecnt == done_cycle(i)) begin
                    model_at(i, ecnt, d, b, dn, t, er, fe);
                    m_tt[i] = t; m_err[i] = er; m_first[i] = fe; m_di[i] = 4'hF;
                    m_act[i] = 0;
                end
            end else if (start) begin
                m_act[i] = 1; m_k[i] = ecnt; m_exp[i] = expected; m_lut[i] = lut;
            end
        end
    end

    // Per-cycle compare, then glitch dut_out on every cycle that is not sampled
    always @(negedge clk) begin
        logic [3:0]  d;
        logic        b, dn;
        logic [15:0] t;
        int          er, fe, c;
        c = ecnt + 1;
        for (int i = 0; i < 2; i++) begin
            model_at(i, c, d, b, dn, t, er, fe);
            chk("dut_in",      i, longint'(dut_in[i]),      longint'(d));
            chk("busy",        i, longint'(busy[i]),        longint'(b));
            chk("done",        i, longint'(done[i]),        longint'(dn));
            chk("truth_table", i, longint'(truth_table[i]), longint'(t));
            chk("err_count",   i, longint'(err_count[i]),   longint'(er));
            chk("err_valid",   i, longint'(err_valid[i]),   longint'(er != 0));
            chk("pass",        i, longint'(pass[i]),        longint'(er == 0));
            if (er != 0) chk("first_err", i, longint'(first_err[i]), longint'(fe));
        end
        for (int i = 0; i < 2; i++) begin
            if (m_act[i] != 0 && c < done_cycle(i) && ((c - m_k[i]) % per_vec(i)) == 0)
                glitch[i] = 1'b0;
            else
                glitch[i] = 1'($urandom_range(0, 1));
        end
    end

    task automatic pulse_start(output int k);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = ecnt;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_act[0] != 0 || m_act[1] != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_act[0] != 0 || m_act[1] != 0) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    task automatic wait_done(input int i, input int budget, output int c);
        c = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done[i]) begin
                c = ecnt + 1;
                break;
            end
        end
        if (c < 0) begin
            errors++;
            $display("FAIL wait_done u%0d: no done within %0d cycles", i, budget);
        end
    endtask

    // Canonical sweep with hand-computed results
    task automatic sweep_lit(input logic [15:0] l, input logic [15:0] e,
                             input logic [15:0] tt_x, input int err_x, input int first_x);
        int k, c0, c1;
        wait_idle(200);
        @(negedge clk);
        lut = l; expected = e;
        pulse_start(k);
        wait_done(0, 100, c0);
        chk("lit_done_lat_s1", 0, longint'(c0 - k), 33);
        chk("lit_tt",          0, longint'(truth_table[0]), longint'(tt_x));
        chk("lit_err_count",   0, longint'(err_count[0]), longint'(err_x));
        chk("lit_err_valid",   0, longint'(err_valid[0]), longint'(err_x != 0));
        chk("lit_pass",        0, longint'(pass[0]), longint'(err_x == 0));
        if (err_x != 0) chk("lit_first_err", 0, longint'(first_err[0]), longint'(first_x));
        wait_done(1, 100, c1);
        chk("lit_done_lat_s3", 1, longint'(c1 - k), 65);
        chk("lit_tt",          1, longint'(truth_table[1]), longint'(tt_x));
        chk("lit_err_count",   1, longint'(err_count[1]), longint'(err_x));
    endtask

    initial begin
        int k, ndone, c;
        rst = 1'b1; start = 1'b0; expected = '0; lut = 16'h6996; glitch = '0;
        repeat (3) @(negedge clk);
        chk("rst_dut_in", 0, longint'(dut_in[0]), 0);
        chk("rst_pass",   0, longint'(pass[0]), 1);
        chk("rst_busy",   0, longint'(busy[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep_lit(16'h6996, 16'h6996, 16'h6996, 0, 0);
        sweep_lit(16'h6996, 16'h6997, 16'h6996, 1, 0);
        sweep_lit(16'h0000, 16'hFFFF, 16'h0000, 16, 0);

        // start re-asserted while busy and during done
        wait_idle(200);
        @(negedge clk);
        lut = 16'h6996; expected = 16'h6996;
        pulse_start(k);
        ndone = 0;
        while (ecnt + 1 <= k + 45) begin
            c = ecnt + 1;
            if (done[0]) ndone++;
            start = (c == k + 5 || c == k + 33);
            @(negedge clk);
        end
        start = 1'b0;
        chk("lit_single_done", 0, longint'(ndone), 1);
        chk("lit_tt_after_restart_try", 0, longint'(truth_table[0]), 16'h6996);

        // reset mid-sweep, then a clean sweep
        wait_idle(200);
        pulse_start(k);
        while (ecnt + 1 < k + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("lit_rst_busy",   0, longint'(busy[0]), 0);
        chk("lit_rst_dut_in", 0, longint'(dut_in[0]), 0);
        chk("lit_rst_err",    0, longint'(err_count[0]), 0);
        chk("lit_rst_pass",   0, longint'(pass[0]), 1);
        sweep_lit(16'h6996, 16'h0F0F, 16'h6996, 8, 0);

        // randomized traffic: random functions, expected churn, start spam, rare resets
        for (int it = 0; it < 30; it++) begin
            wait_idle(200);
            @(negedge clk);
            lut = 16'($urandom); expected = 16'($urandom);
            start = 1'b1;
            for (int n = 0; n < int'($urandom_range(30, 150)); n++) begin
                @(negedge clk);
                start = ($urandom_range(0, 7) == 0) || (it % 5 == 0);
                if ($urandom_range(0, 3) == 0) expected = 16'($urandom);
                rst = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
            start = 1'b0; rst = 1'b0;
        end
        wait_idle(200);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
